// File: rtl/periph_mmio_multi_pkg.sv
// Shared register map, bit positions and helpers for the MMIO peripheral block.
package periph_mmio_multi_pkg;

    localparam logic [31:0] OFF_LED        = 32'h00;
    localparam logic [31:0] OFF_SWITCH     = 32'h04;
    localparam logic [31:0] OFF_DIGI       = 32'h08;
    localparam logic [31:0] OFF_IRQ_STATUS = 32'h0C;
    localparam logic [31:0] OFF_IRQ_MASK   = 32'h10;
    localparam logic [31:0] OFF_TXDATA     = 32'h14;
    localparam logic [31:0] OFF_RXDATA     = 32'h18;
    localparam logic [31:0] OFF_UART_STAT  = 32'h1C;
    localparam logic [31:0] OFF_TIMER0     = 32'h20;

    localparam int TCON_EN       = 0;
    localparam int TCON_IE       = 1;
    localparam int STAT_TX_OVF   = 10;
    localparam int STAT_RX_OVF   = 11;

    // Register slot within one 16-byte timer window
    typedef enum logic [1:0] {
        TREG_TH   = 2'd0,
        TREG_TL   = 2'd1,
        TREG_TCON = 2'd2,
        TREG_NONE = 2'd3
    } treg_e;

    function automatic logic [3:0] sat_cnt4(input logic [31:0] cnt);
        return (cnt > 32'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/periph_mmio_multi_sync_fifo.sv
// Byte-wide synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module periph_mmio_multi_sync_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/periph_mmio_multi.sv
// Memory-mapped peripheral slave: LED/switch/7-seg, reload timers, maskable IRQs, FIFO-buffered UART.
module periph_mmio_multi
    import periph_mmio_multi_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'h4000_0000,
    parameter int          NUM_TIMERS = 2,
    parameter int          LED_W      = 8,
    parameter int          SW_W       = 8,
    parameter int          DIGI_W     = 12,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   switch,
    output logic [DIGI_W-1:0] digi,
    output logic              irqout,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] off;
    logic [31:0] tmr_rel;
    logic        tmr_hit;
    treg_e       tmr_reg;
    logic [NUM_TIMERS-1:0] tmr_sel;

    logic [NUM_TIMERS:0]   irq_mask;
    logic [NUM_TIMERS:0]   irq_status;
    logic [NUM_TIMERS-1:0] tflag, ten, tie, tmr_wrap;
    logic [NUM_TIMERS-1:0][31:0] th, tl;
    logic tx_ovf, rx_ovf;

    logic [7:0]    tx_head, rx_head;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_push_req, tx_bypass, tx_fifo_push, tx_fifo_pop, tx_fire;
    logic          rx_pop;
    logic [31:0]   uart_stat;

    assign off     = addr - BASE;
    assign tmr_rel = off - OFF_TIMER0;
    assign tmr_hit = (off >= OFF_TIMER0) && (tmr_rel < 32'(16 * NUM_TIMERS)) && (tmr_rel[1:0] == 2'b00);
    assign tmr_reg = treg_e'(tmr_rel[3:2]);

    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            tmr_sel[i]  = tmr_hit && (tmr_rel[6:4] == 3'(i));
            tmr_wrap[i] = ten[i] && (tl[i] == 32'hFFFF_FFFF);
        end
    end

    assign irq_status = {!rx_empty, tflag};
    assign irqout     = |(irq_status & irq_mask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led      <= '0;
            digi     <= '0;
            irq_mask <= '0;
            tflag    <= '0;
            ten      <= '0;
            tie      <= '0;
            th       <= '0;
            tl       <= '0;
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
        end else begin
            if (wr && off == OFF_LED)      led      <= wdata[LED_W-1:0];
            if (wr && off == OFF_DIGI)     digi     <= wdata[DIGI_W-1:0];
            if (wr && off == OFF_IRQ_MASK) irq_mask <= wdata[NUM_TIMERS:0];
            // A wrap in the same cycle as a W1C keeps its flag set
            tflag <= (tflag & ~((wr && off == OFF_IRQ_STATUS) ? wdata[NUM_TIMERS-1:0] : '0))
                   | (tmr_wrap & tie);
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (wr && tmr_sel[i] && tmr_reg == TREG_TH) th[i] <= wdata;
                if (wr && tmr_sel[i] && tmr_reg == TREG_TL) tl[i] <= wdata;
                else if (tmr_wrap[i])                       tl[i] <= th[i];
                else if (ten[i])                            tl[i] <= tl[i] + 32'd1;
                if (wr && tmr_sel[i] && tmr_reg == TREG_TCON) begin
                    ten[i] <= wdata[TCON_EN];
                    tie[i] <= wdata[TCON_IE];
                end
            end
            tx_ovf <= (tx_ovf && !(wr && off == OFF_UART_STAT && wdata[STAT_TX_OVF]))
                    || (tx_push_req && tx_full && !tx_fifo_pop);
            rx_ovf <= (rx_ovf && !(wr && off == OFF_UART_STAT && wdata[STAT_RX_OVF]))
                    || (rx_valid && rx_full && !rx_pop);
        end
    end

    // A byte written into an empty FIFO with the transmitter idle skips the FIFO
    assign tx_push_req  = wr && (off == OFF_TXDATA);
    assign tx_fifo_pop  = !tx_empty && tx_ready && !tx_start;
    assign tx_bypass    = tx_push_req && tx_empty && tx_ready && !tx_start;
    assign tx_fifo_push = tx_push_req && !tx_bypass;
    assign tx_fire      = tx_fifo_pop || tx_bypass;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= tx_fire;
            if (tx_fire) tx_data <= tx_empty ? wdata[7:0] : tx_head;
        end
    end

    assign rx_pop = rd && (off == OFF_RXDATA) && !rx_empty;

    periph_mmio_multi_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_fifo_push),
        .push_data (wdata[7:0]),
        .pop       (tx_fifo_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_cnt)
    );

    periph_mmio_multi_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_cnt)
    );

    assign uart_stat = 32'({rx_ovf, tx_ovf, rx_empty, tx_full,
                            sat_cnt4(32'(rx_cnt)), sat_cnt4(32'(tx_cnt))});

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (off)
                OFF_LED:        rdata = 32'(led);
                OFF_SWITCH:     rdata = 32'(switch);
                OFF_DIGI:       rdata = 32'(digi);
                OFF_IRQ_STATUS: rdata = 32'(irq_status);
                OFF_IRQ_MASK:   rdata = 32'(irq_mask);
                OFF_RXDATA:     rdata = rx_empty ? 32'd0 : 32'(rx_head);
                OFF_UART_STAT:  rdata = uart_stat;
                default:        ;
            endcase
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (tmr_sel[i]) begin
                    case (tmr_reg)
                        TREG_TH:   rdata = th[i];
                        TREG_TL:   rdata = tl[i];
                        TREG_TCON: rdata = {30'b0, tie[i], ten[i]};
                        default:   ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_periph_mmio_multi.sv
// Directed bench for periph_mmio_multi with default parameters (2 timers, FIFO depth 8).
module tb_periph_mmio_multi;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_LED = 32'h00, A_SW = 32'h04, A_DIGI = 32'h08, A_ISTAT = 32'h0C,
                            A_MASK = 32'h10, A_TXD = 32'h14, A_RXD = 32'h18, A_USTAT = 32'h1C,
                            A_TH0 = 32'h20, A_TL0 = 32'h24, A_TCON0 = 32'h28,
                            A_TH1 = 32'h30, A_TL1 = 32'h34, A_TCON1 = 32'h38;

    logic        clk = 1'b0;
    logic        reset, rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  led, switch_in;
    logic [11:0] digi;
    logic        irqout, rx_valid, tx_ready, tx_start;
    logic [7:0]  rx_data, tx_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [7:0] txq[$];
    int         txc[$];

    periph_mmio_multi dut (
        .clk      (clk),
        .reset    (reset),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .led      (led),
        .switch   (switch_in),
        .digi     (digi),
        .irqout   (irqout),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset && tx_start) begin
            txq.push_back(tx_data);
            txc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
        addr  = BASE + off;
        wdata = data;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
        addr = BASE + off;
        rd   = 1'b1;
        #1 data = rdata;
        @(negedge clk);
        rd   = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(off, v);
        check(tag, v, exp);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] rst_off[14];
        logic [31:0] rst_exp[14];
        rst_off = '{A_LED, A_SW, A_DIGI, A_ISTAT, A_MASK, A_TXD, A_RXD, A_USTAT,
                    A_TH0, A_TL0, A_TCON0, A_TH1, A_TL1, A_TCON1};
        rst_exp = '{0, 0, 0, 0, 0, 0, 0, 32'h200, 0, 0, 0, 0, 0, 0};

        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        switch_in = 8'h00; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_led", 32'(led), 0);
        check("rst_irqout", 32'(irqout), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) rd_check($sformatf("rst_reg_%02h", rst_off[i]), rst_off[i], rst_exp[i]);

        bus_write(A_LED, 32'h0000_00A5);
        rd_check("led_rd", A_LED, 32'hA5);
        check("led_port", 32'(led), 32'hA5);
        switch_in = 8'h3C;
        rd_check("switch_rd", A_SW, 32'h3C);
        bus_write(A_SW, 32'hFF);
        rd_check("switch_ro", A_SW, 32'h3C);
        bus_write(A_DIGI, 32'hFFFF_F123);
        rd_check("digi_rd", A_DIGI, 32'h123);
        check("digi_port", 32'(digi), 32'h123);
        rd_check("unmapped_2c", 32'h2C, 0);
        rd_check("unmapped_40", 32'h40, 0);
        rd_check("unaligned_01", 32'h01, 0);
        addr = BASE + A_LED; rd = 1'b0; #1;
        check("rdata_no_rd", rdata, 0);
        @(negedge clk);

        // Timer 0 reload and interrupt
        bus_write(A_TH0, 32'hFFFF_FFF0);
        bus_write(A_TL0, 32'hFFFF_FFFE);
        bus_write(A_MASK, 32'h1);
        bus_write(A_TCON0, 32'h3);
        repeat (2) @(negedge clk);
        rd_check("tl0_reload", A_TL0, 32'hFFFF_FFF0);
        rd_check("istat_t0", A_ISTAT, 32'h1);
        check("irqout_t0", 32'(irqout), 1);
        rd_check("tcon0_rd", A_TCON0, 32'h3);
        bus_write(A_TCON0, 32'h0);
        bus_write(A_ISTAT, 32'h1);
        rd_check("istat_w1c", A_ISTAT, 32'h0);
        check("irqout_w1c", 32'(irqout), 0);

        // Timer 1: bus write to TL lands in the wrap cycle
        bus_write(A_TH1, 32'h100);
        bus_write(A_TL1, 32'hFFFF_FFFD);
        bus_write(A_TCON1, 32'h1);
        repeat (2) @(negedge clk);
        bus_write(A_TL1, 32'h55);
        rd_check("tl1_write_wins", A_TL1, 32'h55);
        bus_write(A_TCON1, 32'h0);
        rd_check("istat_no_ie", A_ISTAT, 32'h0);

        // TX: three bytes with transmitter idle
        tx_ready = 1'b1;
        txq.delete(); txc.delete();
        bus_write(A_TXD, 32'h11);
        check("tx_first_start", 32'(tx_start), 1);
        check("tx_first_data", 32'(tx_data), 32'h11);
        bus_write(A_TXD, 32'h22);
        bus_write(A_TXD, 32'h33);
        repeat (10) @(negedge clk);
        check("tx_pulse_cnt", txq.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("tx_byte_%0d", i), (i < txq.size()) ? 32'(txq[i]) : 32'hDEAD, 32'h11 * (i + 1));
        for (int i = 1; i < 3; i++)
            check($sformatf("tx_gap_%0d", i), (i < txc.size()) ? 32'(txc[i] - txc[i-1] >= 2) : 0, 1);

        // TX overflow with transmitter busy
        tx_ready = 1'b0;
        txq.delete(); txc.delete();
        for (int i = 0; i < 9; i++) bus_write(A_TXD, 32'h40 + i);
        rd_check("tx_full_ovf", A_USTAT, 32'h708);
        bus_write(A_USTAT, 32'h400);
        rd_check("tx_ovf_w1c", A_USTAT, 32'h308);
        check("tx_hold_busy", txq.size(), 0);
        tx_ready = 1'b1;
        repeat (25) @(negedge clk);
        check("tx_drain_cnt", txq.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("tx_drain_%0d", i), (i < txq.size()) ? 32'(txq[i]) : 32'hDEAD, 32'h40 + i);
        rd_check("tx_drained", A_USTAT, 32'h200);

        // RX overflow and in-order reads
        for (int i = 0; i < 9; i++) rx_push(8'h81 + 8'(i));
        rd_check("rx_istat", A_ISTAT, 32'h4);
        rd_check("rx_full_ovf", A_USTAT, 32'h880);
        check("irqout_rx_masked", 32'(irqout), 0);
        bus_write(A_MASK, 32'h4);
        check("irqout_rx", 32'(irqout), 1);
        for (int i = 0; i < 8; i++) rd_check($sformatf("rx_rd_%0d", i), A_RXD, 32'h81 + i);
        rd_check("rx_rd_empty", A_RXD, 0);
        rd_check("rx_istat_empty", A_ISTAT, 0);
        check("irqout_rx_empty", 32'(irqout), 0);
        rd_check("rx_ovf_set", A_USTAT, 32'hA00);
        bus_write(A_USTAT, 32'h800);
        rd_check("rx_ovf_w1c", A_USTAT, 32'h200);

        // RX full, push and pop in the same cycle
        for (int i = 0; i < 8; i++) rx_push(8'hC0 + 8'(i));
        rx_data = 8'hD0; rx_valid = 1'b1;
        addr = BASE + A_RXD; rd = 1'b1;
        #1 v = rdata;
        @(negedge clk);
        rx_valid = 1'b0; rd = 1'b0;
        check("rx_simul_head", v, 32'hC0);
        rd_check("rx_simul_stat", A_USTAT, 32'h080);
        for (int i = 1; i < 8; i++) rd_check($sformatf("rx_simul_%0d", i), A_RXD, 32'hC0 + i);
        rd_check("rx_simul_last", A_RXD, 32'hD0);
        rd_check("rx_simul_empty", A_USTAT, 32'h200);

        // Reset in the middle of a transfer
        rx_push(8'h77);
        bus_write(A_TXD, 32'h5A);
        check("mid_tx_start", 32'(tx_start), 1);
        reset = 1'b0;
        #1;
        check("rst_async_start", 32'(tx_start), 0);
        check("rst_async_data", 32'(tx_data), 0);
        check("rst_async_led", 32'(led), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rd_check("rst_flush_stat", A_USTAT, 32'h200);
        rd_check("rst_flush_rx", A_RXD, 0);
        rd_check("rst_mask", A_MASK, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
